// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmitter with SYNC, bit stuffing, NRZI and EOP
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [OW-1:0] ones;
  logic [2:0] idx, idx_n;
  logic [7:0] hold, sr, next_byte;
  logic hold_full, hold_last, cur_last, lvl;
  logic wrap, hs, have_next, next_last, byte_end, launch, nb, load, under;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign hs = tx_valid && tx_ready;
  assign have_next = hold_full || hs;
  assign next_byte = hold_full ? hold : tx_data;
  assign next_last = hold_full ? hold_last : tx_last;
  assign byte_end = idx == 3'd7 && (state == STUFF || (state == DATA && ones != OW'(STUFF_LEN)));
  assign tx_ready = !hold_full && !cur_last && state != EOP_SE0 && state != EOP_J;
  assign tx_busy = state != IDLE;
  assign d_plus = state != EOP_SE0 && lvl;
  assign d_minus = state != EOP_SE0 && !lvl;
  // pick the next line symbol at each bit boundary; a 0 value toggles the NRZI level
  always_comb begin
    state_n = state;
    idx_n = idx;
    launch = 1'b0;
    nb = 1'b0;
    load = 1'b0;
    under = 1'b0;
    if (state == IDLE) begin
      if (hs) begin
        state_n = SYNC;
        idx_n = 3'd0;
        launch = 1'b1;
      end
    end else if (wrap) begin
      if (byte_end) begin
        if (!cur_last && have_next) begin
          state_n = DATA;
          idx_n = 3'd0;
          launch = 1'b1;
          nb = next_byte[0];
          load = 1'b1;
        end else begin
          state_n = EOP_SE0;
          idx_n = 3'd0;
          under = !cur_last;
        end
      end else begin
        case (state)
          SYNC: begin
            launch = 1'b1;
            if (idx == 3'd7) begin
              state_n = DATA;
              idx_n = 3'd0;
              nb = next_byte[0];
              load = 1'b1;
            end else begin
              idx_n = idx + 3'd1;
              nb = idx == 3'd6;
            end
          end
          DATA: begin
            launch = 1'b1;
            if (ones == OW'(STUFF_LEN)) state_n = STUFF;
            else begin
              idx_n = idx + 3'd1;
              nb = sr[idx + 3'd1];
            end
          end
          STUFF: begin
            state_n = DATA;
            idx_n = idx + 3'd1;
            launch = 1'b1;
            nb = sr[idx + 3'd1];
          end
          EOP_SE0: begin
            idx_n = 3'd1;
            state_n = idx == 3'd1 ? EOP_J : EOP_SE0;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end
  // state, bit timer, NRZI level, ones counter and the two byte registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      ones <= '0;
      lvl <= 1'b1;
      hold_full <= 1'b0;
      cur_last <= 1'b0;
      tx_done <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      lvl <= state_n == EOP_J ? 1'b1 : (launch && !nb) ? !lvl : lvl;
      if (launch) ones <= nb ? ones + 1'b1 : '0;
      hold_full <= hold_full ? !load : hs && !load;
      if (load) cur_last <= next_last;
      else if (state_n == IDLE) cur_last <= 1'b0;
      tx_done <= state == EOP_J && wrap;
      tx_underrun <= under;
    end
  end
  // data registers need no reset; their contents are qualified by hold_full and state
  always_ff @(posedge clk) begin
    if (hs) begin
      hold <= tx_data;
      hold_last <= tx_last;
    end
    if (load) sr <= next_byte;
  end
endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- Full-speed USB transmit-side line encoder; the counterpart of the receive-path EOP detection and NRZI decode.
- Accepts packet bytes over a valid/ready handshake and automatically prepends SYNC.
- Serializes each byte LSB-first, applies bit stuffing and NRZI, and finishes with EOP: SE0, SE0, J.
- Drives d_plus and d_minus directly to the bus transceiver.

Parameters:
- CLKS_PER_BIT, 4, system clocks per USB bit time (48 MHz clock / 12 Mbps).
- STUFF_LEN, 6, count of consecutive 1 bits that forces insertion of a stuffed 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  packet byte to send.
- tx_valid  input  1  tx_data/tx_last valid.
- tx_last  input  1  qualifies tx_data as the final byte of the packet.
- tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready.
- d_plus  output  1  USB D+ line.
- d_minus  output  1  USB D- line.
- tx_busy  output  1  packet in progress (SYNC through EOP).
- tx_done  output  1  one-cycle pulse on completion of EOP.
- tx_underrun  output  1  one-cycle pulse when the data stream starves mid-packet.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: d_plus=1, d_minus=0 (J/idle), tx_ready=1, tx_busy=0, tx_done=0, tx_underrun=0; holding register empty; FSM in IDLE; stuff count 0.
- Line states: J = (1,0), K = (0,1), SE0 = (0,0). The block never drives (1,1).
- One-byte holding register plus one shift register. tx_ready = holding register empty.
- Holding register loads on handshake and moves to the shift register when the current byte's last bit time (including any trailing stuff) ends.
- States:
  - IDLE: drive J. On handshake, go to SYNC; the first SYNC bit is driven starting the next cycle. tx_busy rises on the same edge.
  - SYNC: send 8'h80 LSB-first (0000_0001) through the NRZI path → K J K J K J K K. At SYNC end, go to DATA with the held byte.
  - DATA: send 8 bits LSB-first; each bit lasts CLKS_PER_BIT cycles.
  - STUFF: one bit time of 0 (line toggles); then return to DATA, or go to EOP_SE0 if the stuffed bit followed the final data bit.
  - EOP_SE0: 2 bit times of SE0.
  - EOP_J: 1 bit time of J, then IDLE. tx_done pulses in the cycle IDLE is entered; tx_busy falls the same cycle.
- NRZI: a 0 bit toggles J↔K at the bit boundary; a 1 bit holds the line. The NRZI register starts at J for each packet.
- Bit stuffing:
  - The ones counter increments on each 1 bit (SYNC included) and clears on any 0 or stuffed bit.
  - When it reaches STUFF_LEN after a bit, a STUFF bit is inserted next.
  - This also applies after the final data bit: the stuff is sent before EOP.
- Outputs change only at bit-time boundaries: the bit-timer counts 0..CLKS_PER_BIT-1 and the next bit is launched when it wraps.
- After the final byte (tx_last) is loaded into the shift register, tx_ready stays 0 until the next IDLE. Handshakes offered during that window are not accepted.
- Underrun: if the shift register empties, tx_last has not been seen, and the holding register is empty, then:
  - pulse tx_underrun;
  - go directly to EOP_SE0 (normal EOP);
  - tx_done still pulses at the end.
- Simultaneous events: a handshake in the same cycle the holding register drains is legal; the new byte is stored and no underrun occurs.
- Reset mid-packet: on the next edge, all outputs return to their reset values, the packet is abandoned, and no tx_done is produced.
- Packet length in bit times = 8 (SYNC) + 8·N + stuff_bits + 3 (EOP). Clocks = CLKS_PER_BIT × bit times.

Test Plan:
- Reset → d_plus=1, d_minus=0, tx_ready=1, tx_busy=0. Also assert rst mid-DATA → next cycle J idle, tx_busy=0, no tx_done.
- Single byte 0x00 with tx_last → line per bit: K J K J K J K K | J K J K J K J K | SE0 SE0 J; 19 bit times = 76 clocks; tx_done pulses once.
- Single byte 0xFF with tx_last:
  - SYNC;
  - data K K K K K, then stuff to J, then J J J (9 bit times);
  - then EOP; exactly one stuff bit.
- Byte 0xFC with tx_last: bits 0,0,1,1,1,1,1,1 → six trailing ones → stuffed 0 (toggle) is sent before SE0.
- Back-to-back 0xFF, 0xFF (second with tx_last), second byte presented while the first is shifting:
  - stuffs after byte1 bit5 and after byte2 bit3;
  - no gap between bytes;
  - tx_ready deasserts after byte2 is loaded.
- Byte 0x55 without tx_last and no follow-up byte → tx_underrun pulses after byte1's last bit, SE0 SE0 J follows, then tx_done pulses.
